// File: rtl/enoc_ingress_buffer.sv
// enoc_ingress_buffer: first-word fall-through FIFO between a node source and a router local input.
// Ports: clk, reset_n (async active-low) | i_data/i_data_val (source packet) -> o_full (refuse)
//        o_data/o_data_val (head packet) <- i_en (router accepts) | o_stall_cnt (refused cycles, saturating)
module enoc_ingress_buffer #(
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 4,
    parameter int STALL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_data_val,
    output logic                   o_full,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_data_val,
    input  logic                   i_en,
    output logic [STALL_WIDTH-1:0] o_stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic wr, rd;
    // Full is taken from registered count only, so a same-cycle read never opens the door.
    assign o_full     = count == (AW+1)'(DEPTH);
    assign o_data_val = count != '0;
    assign o_data     = mem[rd_ptr];
    assign wr         = i_data_val && !o_full;
    assign rd         = o_data_val && i_en;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            o_stall_cnt <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
            if (i_data_val && o_full && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + STALL_WIDTH'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= i_data;
    end
endmodule
